bp_be_cache_req_arbiter: RTL and testbench
==========================================

BP_BE_CACHE_REQ_ARBITER -- requirements
Module: bp_be_cache_req_arbiter

Interface
REQ-001 Parameter req_width_p, default 64: width of one cache request packet.
REQ-002 Parameter metadata_width_p, default 8: width of one cache request metadata packet.
REQ-003 Clock and reset SHALL be one clock and an asynchronous, active-low reset.
REQ-004 clk_i  in  1  sole clock; all state on rising edge.
REQ-005 reset_n_i  in  1  asynchronous active-low reset.
REQ-006 reqN_i  in  req_width_p  request packet from requester N (N=0 D$ miss path, N=1 page-table walker).
REQ-007 reqN_v_i  in  1  requester N request valid.
REQ-008 reqN_ready_o  out  1  requester N request accepted this cycle (valid-ready).
REQ-009 reqN_metadata_i  in  metadata_width_p  requester N metadata.
REQ-010 reqN_metadata_v_i  in  1  requester N metadata valid.
REQ-011 reqN_complete_o  out  1  one-cycle pulse: requester N transaction complete.
REQ-012 cache_req_o  out  req_width_p  request to LCE.
REQ-013 cache_req_v_o  out  1  request to LCE valid.
REQ-014 cache_req_ready_i  in  1  LCE ready.
REQ-015 cache_req_metadata_o  out  metadata_width_p  metadata to LCE.
REQ-016 cache_req_metadata_v_o  out  1  metadata to LCE valid.
REQ-017 cache_req_complete_i  in  1  LCE transaction complete.

Function
REQ-018 FSM states SHALL be e_idle, e_send, e_meta, e_busy; exactly one LCE transaction in flight.
REQ-019 e_idle: reqN_ready_o SHALL be 1 only for the picked requester; on reqN_v_i&reqN_ready_o, latch reqN_i and owner id, go e_send.
REQ-020 Pick: one valid -> that one; both valid -> requester not granted last (round-robin); after reset req0 wins first tie.
REQ-021 e_send: cache_req_v_o=1 and cache_req_o=latched packet held stable until cache_req_ready_i=1; then go e_meta; request latency accept-to-cache_req_v_o exactly 1 cycle.
REQ-022 e_meta: cache_req_metadata_o/cache_req_metadata_v_o SHALL pass through the owner's metadata combinationally; on owner metadata_v_i go e_busy.
REQ-023 Metadata valid from the owner before e_meta, or from the non-owner at any time, SHALL be ignored.
REQ-024 e_busy: on cache_req_complete_i, reqOwner_complete_o=1 same cycle (combinational), update last-granted pointer, go e_idle.
REQ-025 cache_req_complete_i in e_meta together with owner metadata_v_i SHALL be treated as completion: pulse complete, go e_idle.
REQ-026 cache_req_complete_i in e_idle or e_send SHALL be ignored.
REQ-027 New request SHALL NOT be accepted in the cycle completion is signalled; earliest next accept is the following cycle.
REQ-028 Non-owner reqN_ready_o and reqN_complete_o SHALL be 0 outside e_idle.

Reset
REQ-029 reset_n_i low SHALL asynchronously force e_idle, last-granted=req1, and all _o valid/ready/complete outputs 0 (ready outputs follow e_idle once reset deasserts), aborting any transaction in flight.
REQ-030 Latched packet registers need no reset value.

Structure
REQ-031 State enum bp_be_cache_req_arb_state_e SHALL live in bp_be_pkg.
REQ-032 Two-input round-robin picker SHALL be sub-module bp_be_cache_req_arb_rr (inputs v0/v1, last; outputs grant one-hot).
REQ-033 All other logic SHALL be local to bp_be_cache_req_arbiter.

Verification
REQ-034 req0_v_i=1 alone, req0_i=0xA5 -> req0_ready_o=1 cycle 0, cache_req_v_o=1 with 0xA5 cycle 1.
REQ-035 Both valid every cycle, immediate ready/metadata/complete -> grants alternate 0,1,0,1 starting with 0.
REQ-036 cache_req_ready_i held 0 for 5 cycles -> cache_req_v_o=1 and packet unchanged all 5 cycles; e_meta entered on cycle ready=1.
REQ-037 req1 metadata_v_i=1 (0x3C) while req0 owns in e_meta -> no metadata_v_o; owner metadata 0x5A -> metadata_o=0x5A same cycle.
REQ-038 reset_n_i low mid-e_busy -> all outputs 0 immediately; after release, stray cache_req_complete_i produces no complete pulse.

Source files
------------

// File: rtl/bp_be_pkg.sv
// Shared backend definitions for the cache request arbiter.
//   bp_be_arb_reqs_lp           : number of requesters feeding the arbiter
//   bp_be_cache_req_arb_state_e : arbiter transaction state
package bp_be_pkg;

  localparam int unsigned bp_be_arb_reqs_lp = 2;

  typedef enum logic [1:0] {
    e_idle,
    e_send,
    e_meta,
    e_busy
  } bp_be_cache_req_arb_state_e;

endpackage : bp_be_pkg

// File: rtl/bp_be_cache_req_arb_rr.sv
// Two-input round-robin picker.
//   v0_i, v1_i : requester valids
//   last_i     : requester granted most recently (0 or 1)
//   grant_o    : one-hot grant, all-zero when nobody is valid
module bp_be_cache_req_arb_rr
  import bp_be_pkg::*;
(
  input  logic                         v0_i,
  input  logic                         v1_i,
  input  logic                         last_i,
  output logic [bp_be_arb_reqs_lp-1:0] grant_o
);

  // On a tie, the requester that was not granted last wins
  always_comb begin
    grant_o = '0;
    if (v0_i && v1_i) begin
      grant_o[0] = last_i;
      grant_o[1] = ~last_i;
    end else begin
      grant_o[0] = v0_i;
      grant_o[1] = v1_i;
    end
  end

endmodule : bp_be_cache_req_arb_rr

// File: rtl/bp_be_cache_req_arbiter.sv
// Arbitrates the D$ miss path (req0) and the page-table walker (req1) onto a
// single LCE request port, one transaction in flight at a time.
//   clk_i, reset_n_i        : clock, async active-low reset
//   reqN_i / reqN_v_i       : request packet and valid from requester N
//   reqN_ready_o            : request accepted (only the picked requester, idle only)
//   reqN_metadata_i / _v_i  : requester N metadata
//   reqN_complete_o         : one-cycle completion pulse to requester N
//   cache_req_o / _v_o      : latched request to the LCE, ready from cache_req_ready_i
//   cache_req_metadata_o/_v_o : owner metadata passed through to the LCE
//   cache_req_complete_i    : LCE transaction complete
module bp_be_cache_req_arbiter
  import bp_be_pkg::*;
#(
  parameter int unsigned req_width_p      = 64,
  parameter int unsigned metadata_width_p = 8
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,

  input  logic [req_width_p-1:0]      req0_i,
  input  logic                        req0_v_i,
  output logic                        req0_ready_o,
  input  logic [metadata_width_p-1:0] req0_metadata_i,
  input  logic                        req0_metadata_v_i,
  output logic                        req0_complete_o,

  input  logic [req_width_p-1:0]      req1_i,
  input  logic                        req1_v_i,
  output logic                        req1_ready_o,
  input  logic [metadata_width_p-1:0] req1_metadata_i,
  input  logic                        req1_metadata_v_i,
  output logic                        req1_complete_o,

  output logic [req_width_p-1:0]      cache_req_o,
  output logic                        cache_req_v_o,
  input  logic                        cache_req_ready_i,
  output logic [metadata_width_p-1:0] cache_req_metadata_o,
  output logic                        cache_req_metadata_v_o,
  input  logic                        cache_req_complete_i
);

  bp_be_cache_req_arb_state_e r_state;
  logic                       r_owner;
  logic                       r_last;
  logic [req_width_p-1:0]     r_req;

  logic [bp_be_arb_reqs_lp-1:0] w_grant;
  logic                         w_idle;
  logic                         w_accept;
  logic                         w_owner_meta_v;
  logic [metadata_width_p-1:0]  w_owner_meta;
  logic                         w_done;

  bp_be_cache_req_arb_rr u_rr (
    .v0_i    (req0_v_i),
    .v1_i    (req1_v_i),
    .last_i  (r_last),
    .grant_o (w_grant)
  );

  // Handshake and pass-through decode from the current state
  always_comb begin
    w_owner_meta_v = r_owner ? req1_metadata_v_i : req0_metadata_v_i;
    w_owner_meta   = r_owner ? req1_metadata_i   : req0_metadata_i;

    // Ready is held low while reset is asserted even though the state is idle
    w_idle       = (r_state == e_idle) && reset_n_i;
    req0_ready_o = w_idle && w_grant[0];
    req1_ready_o = w_idle && w_grant[1];
    // The grant is only ever set for a valid requester
    w_accept     = w_idle && (|w_grant);

    cache_req_v_o          = (r_state == e_send);
    cache_req_o            = r_req;
    cache_req_metadata_v_o = (r_state == e_meta) && w_owner_meta_v;
    cache_req_metadata_o   = w_owner_meta;

    // Completion arriving with the owner's metadata short-circuits e_busy
    w_done = cache_req_complete_i &&
             ((r_state == e_busy) || ((r_state == e_meta) && w_owner_meta_v));

    req0_complete_o = w_done && !r_owner;
    req1_complete_o = w_done &&  r_owner;
  end

  // Transaction state, owner and round-robin pointer
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= e_idle;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      case (r_state)
        e_idle: begin
          if (w_accept) begin
            r_owner <= w_grant[1];
            r_state <= e_send;
          end
        end
        e_send: begin
          if (cache_req_ready_i) r_state <= e_meta;
        end
        e_meta: begin
          if (w_done) begin
            r_last  <= r_owner;
            r_state <= e_idle;
          end else if (w_owner_meta_v) begin
            r_state <= e_busy;
          end
        end
        e_busy: begin
          if (w_done) begin
            r_last  <= r_owner;
            r_state <= e_idle;
          end
        end
        default: r_state <= e_idle;
      endcase
    end
  end

  // Request packet capture; contents are only observed while valid
  always_ff @(posedge clk_i) begin
    if (w_accept) r_req <= w_grant[1] ? req1_i : req0_i;
  end

endmodule : bp_be_cache_req_arbiter

// File: tb/tb_bp_be_cache_req_arbiter.sv
module tb_bp_be_cache_req_arbiter;

  localparam int unsigned RW = 64;
  localparam int unsigned MW = 8;

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic [RW-1:0] req0_i, req1_i;
  logic          req0_v_i, req1_v_i;
  logic          req0_ready_o, req1_ready_o;
  logic [MW-1:0] req0_metadata_i, req1_metadata_i;
  logic          req0_metadata_v_i, req1_metadata_v_i;
  logic          req0_complete_o, req1_complete_o;
  logic [RW-1:0] cache_req_o;
  logic          cache_req_v_o;
  logic          cache_req_ready_i;
  logic [MW-1:0] cache_req_metadata_o;
  logic          cache_req_metadata_v_o;
  logic          cache_req_complete_i;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk_i = ~clk_i;

  bp_be_cache_req_arbiter #(.req_width_p(RW), .metadata_width_p(MW)) dut (
    .clk_i                  (clk_i),
    .reset_n_i              (reset_n_i),
    .req0_i                 (req0_i),
    .req0_v_i               (req0_v_i),
    .req0_ready_o           (req0_ready_o),
    .req0_metadata_i        (req0_metadata_i),
    .req0_metadata_v_i      (req0_metadata_v_i),
    .req0_complete_o        (req0_complete_o),
    .req1_i                 (req1_i),
    .req1_v_i               (req1_v_i),
    .req1_ready_o           (req1_ready_o),
    .req1_metadata_i        (req1_metadata_i),
    .req1_metadata_v_i      (req1_metadata_v_i),
    .req1_complete_o        (req1_complete_o),
    .cache_req_o            (cache_req_o),
    .cache_req_v_o          (cache_req_v_o),
    .cache_req_ready_i      (cache_req_ready_i),
    .cache_req_metadata_o   (cache_req_metadata_o),
    .cache_req_metadata_v_o (cache_req_metadata_v_o),
    .cache_req_complete_i   (cache_req_complete_i)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: transaction progress of the single in-flight request
  bit          m_busy    = 1'b0;  // a request has been accepted and not completed
  bit          m_owner   = 1'b0;
  logic [RW-1:0] m_pkt   = '0;
  bit          m_sent    = 1'b0;  // LCE has taken the request
  bit          m_meta_ok = 1'b0;  // owner metadata has been delivered
  bit          m_last    = 1'b1;  // requester granted most recently

  // One clock of stimulus: drive after the falling edge, check, advance model
  task automatic step(input logic rst, input logic v0, input logic v1,
                      input logic [RW-1:0] d0, input logic [RW-1:0] d1,
                      input logic mv0, input logic mv1,
                      input logic [MW-1:0] m0, input logic [MW-1:0] m1,
                      input logic crdy, input logic ccmp);
    bit e_r0, e_r1, e_cv, e_mv, e_c0, e_c1, in_meta, own_mv, done;
    logic [MW-1:0] own_m;
    @(negedge clk_i);
    reset_n_i = rst;
    req0_v_i = v0; req1_v_i = v1; req0_i = d0; req1_i = d1;
    req0_metadata_v_i = mv0; req1_metadata_v_i = mv1;
    req0_metadata_i = m0; req1_metadata_i = m1;
    cache_req_ready_i = crdy; cache_req_complete_i = ccmp;
    #1;
    own_mv  = m_owner ? mv1 : mv0;
    own_m   = m_owner ? m1 : m0;
    e_r0 = 0; e_r1 = 0; e_cv = 0; e_mv = 0; e_c0 = 0; e_c1 = 0; done = 0;
    in_meta = rst && m_busy && m_sent && !m_meta_ok;
    if (rst) begin
      if (!m_busy) begin
        if (v0 && v1) begin e_r0 = m_last; e_r1 = !m_last; end
        else begin e_r0 = v0; e_r1 = v1; end
      end else if (!m_sent) begin
        e_cv = 1;
      end else if (!m_meta_ok) begin
        e_mv = own_mv;
        done = own_mv && ccmp;
      end else begin
        done = ccmp;
      end
      e_c0 = done && !m_owner;
      e_c1 = done && m_owner;
    end
    chk("req0_ready", 64'(req0_ready_o), 64'(e_r0));
    chk("req1_ready", 64'(req1_ready_o), 64'(e_r1));
    chk("cache_req_v", 64'(cache_req_v_o), 64'(e_cv));
    if (e_cv) chk("cache_req", 64'(cache_req_o), 64'(m_pkt));
    chk("meta_v", 64'(cache_req_metadata_v_o), 64'(e_mv));
    if (in_meta) chk("meta", 64'(cache_req_metadata_o), 64'(own_m));
    chk("req0_complete", 64'(req0_complete_o), 64'(e_c0));
    chk("req1_complete", 64'(req1_complete_o), 64'(e_c1));
    if (!rst) begin
      m_busy = 0; m_last = 1;
    end else if (!m_busy) begin
      if (e_r0 || e_r1) begin
        m_busy = 1; m_owner = e_r1; m_pkt = e_r1 ? d1 : d0;
        m_sent = 0; m_meta_ok = 0;
      end
    end else if (!m_sent) begin
      if (crdy) m_sent = 1;
    end else if (done) begin
      m_busy = 0; m_last = m_owner;
    end else if (!m_meta_ok && own_mv) begin
      m_meta_ok = 1;
    end
  endtask

  task automatic idle_step(input logic rst);
    step(rst, 0, 0, '0, '0, 0, 0, '0, '0, 0, 0);
  endtask

  initial begin
    logic [RW-1:0] a5;
    reset_n_i = 0;
    req0_v_i = 0; req1_v_i = 0; req0_i = '0; req1_i = '0;
    req0_metadata_v_i = 0; req1_metadata_v_i = 0;
    req0_metadata_i = '0; req1_metadata_i = '0;
    cache_req_ready_i = 0; cache_req_complete_i = 0;
    idle_step(0);
    idle_step(0);
    idle_step(1);

    // Single requester: accept, then request visible one cycle later
    a5 = 64'hA5;
    step(1, 1, 0, a5, '0, 0, 0, '0, '0, 0, 0);
    step(1, 0, 0, '0, '0, 0, 0, '0, '0, 1, 0);
    chk("meta_wrong_owner_v", 64'(cache_req_metadata_v_o), 64'h0);
    // Non-owner metadata ignored, owner metadata passes through
    step(1, 0, 0, '0, '0, 0, 1, 8'h11, 8'h3C, 0, 0);
    step(1, 0, 0, '0, '0, 1, 0, 8'h5A, 8'h3C, 0, 0);
    chk("meta_5a", 64'(cache_req_metadata_o), 64'h5A);
    step(1, 0, 0, '0, '0, 0, 0, '0, '0, 0, 1);

    // LCE back-pressure holds the request stable
    step(1, 0, 1, '0, 64'h1234_5678_9ABC_DEF0, 0, 0, '0, '0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, '0, '0, 0, 0, '0, '0, 0, 0);
    step(1, 0, 0, '0, '0, 0, 0, '0, '0, 1, 0);
    step(1, 0, 0, '0, '0, 0, 1, '0, 8'h77, 0, 1);

    // Reset to establish round-robin start, then persistent contention
    idle_step(0);
    for (int i = 0; i < 24; i++)
      step(1, 1, 1, 64'(i), 64'(i + 100), 1, 1, 8'(i), 8'(i + 1), 1, 1);

    // Reset in the middle of the busy phase aborts the transaction
    step(1, 1, 0, 64'hBEEF, '0, 0, 0, '0, '0, 0, 0);
    step(1, 0, 0, '0, '0, 0, 0, '0, '0, 1, 0);
    step(1, 0, 0, '0, '0, 1, 0, 8'h22, '0, 0, 0);
    step(0, 1, 1, '0, '0, 1, 1, '0, '0, 1, 1);
    step(1, 0, 0, '0, '0, 1, 1, '0, '0, 1, 1);
    step(1, 0, 0, '0, '0, 0, 0, '0, '0, 0, 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
           {$urandom, $urandom}, {$urandom, $urandom},
           ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 4),
           8'($urandom), 8'($urandom),
           ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 3));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_bp_be_cache_req_arbiter
